// File: rtl/sync_fifo_wide_to_narrow_if.sv
// Bus bundle for sync_fifo_wide_to_narrow: wide write side, narrow read side, flags.
// Handshake: a write is taken on a rising edge when wr_en && !full, and a read when rd_en && !empty.
// Requests against the opposite flag are dropped and answered by a one-cycle overflow/underflow pulse.
interface sync_fifo_wide_to_narrow_if #(
  parameter int OUT_WIDTH  = 72,
  parameter int RATIO      = 4,
  parameter int DEPTH_BITS = 4
);
  localparam int CNT_W = DEPTH_BITS + $clog2(RATIO) + 1;

  logic [OUT_WIDTH*RATIO-1:0] din;
  logic                       wr_en;
  logic                       full;
  logic                       almost_full;
  logic                       overflow;
  logic                       rd_en;
  logic [OUT_WIDTH-1:0]       dout;
  logic                       empty;
  logic                       almost_empty;
  logic                       underflow;
  logic [CNT_W-1:0]           rd_count;

  modport master (
    output din, wr_en, rd_en,
    input  full, almost_full, overflow, dout, empty, almost_empty, underflow, rd_count
  );

  modport slave (
    input  din, wr_en, rd_en,
    output full, almost_full, overflow, dout, empty, almost_empty, underflow, rd_count
  );
endinterface

// File: rtl/sync_fifo_wide_to_narrow.sv
// Single-clock FIFO taking RATIO*OUT_WIDTH-bit words and returning them as OUT_WIDTH slices, MSB first.
// Define SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN for first-word-fall-through dout; default is registered dout.
module sync_fifo_wide_to_narrow #(
  parameter int OUT_WIDTH  = 72,
  parameter int RATIO      = 4,
  parameter int DEPTH_BITS = 4,
  parameter int AF_MARGIN  = 2,
  parameter int AE_THRESH  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  sync_fifo_wide_to_narrow_if.slave bus
);
  localparam int W     = OUT_WIDTH * RATIO;
  localparam int DEPTH = 2 ** DEPTH_BITS;
  localparam int SI_W  = $clog2(RATIO);
  localparam int WC_W  = DEPTH_BITS + 1;
  localparam int CNT_W = DEPTH_BITS + SI_W + 1;

  localparam logic [WC_W-1:0] DEPTH_V = WC_W'(DEPTH);
  localparam logic [SI_W-1:0] SI_LAST = SI_W'(RATIO - 1);
  localparam logic [31:0]     AF_M    = 32'(AF_MARGIN);
  localparam logic [31:0]     AE_M    = 32'(AE_THRESH);
  localparam logic            AF_RST  = (AF_MARGIN >= DEPTH);

  logic [W-1:0]          mem_q [DEPTH];
  logic [DEPTH_BITS-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [SI_W-1:0]       si_q, si_d;
  logic [WC_W-1:0]       wc_q, wc_d, free_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  full_q, full_d, af_q, af_d;
  logic                  empty_q, empty_d, ae_q, ae_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d;
  logic                  wr_acc, rd_acc, ent_free;
  logic [OUT_WIDTH-1:0]  head_slice;

  always_comb begin
    wr_acc     = bus.wr_en & ~full_q;
    rd_acc     = bus.rd_en & ~empty_q;
    ent_free   = rd_acc & (si_q == SI_LAST);
    head_slice = mem_q[rp_q][OUT_WIDTH*(RATIO-1-int'(si_q)) +: OUT_WIDTH];

    wp_d = wr_acc   ? wp_q + DEPTH_BITS'(1) : wp_q;
    rp_d = ent_free ? rp_q + DEPTH_BITS'(1) : rp_q;
    si_d = rd_acc   ? si_q + SI_W'(1)       : si_q;

    // A freeing read and an accepted write in the same edge cancel out.
    wc_d = wc_q;
    if (wr_acc && !ent_free) wc_d = wc_q + WC_W'(1);
    if (!wr_acc && ent_free) wc_d = wc_q - WC_W'(1);

    cnt_d   = {wc_d, {SI_W{1'b0}}} - CNT_W'(si_d);
    free_d  = DEPTH_V - wc_d;
    full_d  = (wc_d == DEPTH_V);
    af_d    = (32'(free_d) <= AF_M);
    empty_d = (cnt_d == '0);
    ae_d    = (32'(cnt_d) <= AE_M);
    ovf_d   = bus.wr_en & full_q;
    unf_d   = bus.rd_en & empty_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q    <= '0;
      rp_q    <= '0;
      si_q    <= '0;
      wc_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      af_q    <= AF_RST;
      empty_q <= 1'b1;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      si_q    <= si_d;
      wc_q    <= wc_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      af_q    <= af_d;
      empty_q <= empty_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage is not reset; occupancy state alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wp_q] <= bus.din;
  end

`ifdef SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN
  assign bus.dout = empty_q ? '0 : head_slice;
`else
  logic [OUT_WIDTH-1:0] dout_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         dout_q <= '0;
    else if (rd_acc) dout_q <= head_slice;
  end

  assign bus.dout = dout_q;
`endif

  assign bus.full         = full_q;
  assign bus.almost_full  = af_q;
  assign bus.overflow     = ovf_q;
  assign bus.empty        = empty_q;
  assign bus.almost_empty = ae_q;
  assign bus.underflow    = unf_q;
  assign bus.rd_count     = cnt_q;
endmodule

// File: tb/tb_sync_fifo_wide_to_narrow.sv
// Bench for sync_fifo_wide_to_narrow: directed boundary cases plus random traffic against a
// narrow-word queue model; honours SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN when it is defined.
module tb_sync_fifo_wide_to_narrow;
  localparam int OW    = 72;
  localparam int R     = 4;
  localparam int DB    = 4;
  localparam int AFM   = 2;
  localparam int AET   = 4;
  localparam int DEPTH = 2 ** DB;
  localparam int W     = OW * R;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   cmp_en = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  sync_fifo_wide_to_narrow_if #(.OUT_WIDTH(OW), .RATIO(R), .DEPTH_BITS(DB)) bus ();

  sync_fifo_wide_to_narrow #(
    .OUT_WIDTH(OW), .RATIO(R), .DEPTH_BITS(DB), .AF_MARGIN(AFM), .AE_THRESH(AET)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  always #5 clk = ~clk;

  // Model: the FIFO is a queue of narrow words; every flag follows from its length.
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] m_dout;
  logic          m_ovf, m_unf;

  always @(posedge clk or posedge rst) begin : model
    int n;
    bit was_full;
    if (rst) begin
      exp_q.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      n        = exp_q.size();
      was_full = ((n + R - 1) / R) == DEPTH;
      m_ovf    = bus.wr_en && was_full;
      m_unf    = bus.rd_en && (n == 0);
      if (bus.rd_en && n != 0) m_dout = exp_q.pop_front();
      if (bus.wr_en && !was_full)
        for (int k = 0; k < R; k++) exp_q.push_back(bus.din[W-1-k*OW -: OW]);
    end
  end

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard compare, once per cycle away from the active edge.
  always @(negedge clk) begin : cmp
    int n, wc;
    if (cmp_en) begin
      n  = exp_q.size();
      wc = (n + R - 1) / R;
      check("rd_count",     96'(bus.rd_count),     96'(n));
      check("empty",        96'(bus.empty),        96'(n == 0));
      check("almost_empty", 96'(bus.almost_empty), 96'(n <= AET));
      check("full",         96'(bus.full),         96'(wc == DEPTH));
      check("almost_full",  96'(bus.almost_full),  96'((DEPTH - wc) <= AFM));
      check("overflow",     96'(bus.overflow),     96'(m_ovf));
      check("underflow",    96'(bus.underflow),    96'(m_unf));
`ifdef SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN
      if (n != 0) check("dout", 96'(bus.dout), 96'(exp_q[0]));
`else
      check("dout", 96'(bus.dout), 96'(m_dout));
`endif
    end
  end

  // driver tasks
  task automatic step(input bit w, input bit r, input logic [W-1:0] d);
    bus.wr_en = w;
    bus.rd_en = r;
    bus.din   = d;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] rnd_wide();
    logic [W-1:0] v;
    v = '0;
    for (int k = 0; k < (W + 31) / 32; k++) v = (v << 32) | W'($urandom());
    return v;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_count"}, 96'(bus.rd_count),     96'(0));
    check({tag, "_empty"},    96'(bus.empty),        96'(1));
    check({tag, "_ae"},       96'(bus.almost_empty), 96'(1));
    check({tag, "_full"},     96'(bus.full),         96'(0));
    check({tag, "_af"},       96'(bus.almost_full),  96'(0));
    check({tag, "_ovf"},      96'(bus.overflow),     96'(0));
    check({tag, "_unf"},      96'(bus.underflow),    96'(0));
    check({tag, "_dout"},     96'(bus.dout),         96'(0));
  endtask

  task automatic drain(input int limit);
    for (int k = 0; k < limit && exp_q.size() > 0; k++) step(1'b0, 1'b1, '0);
  endtask

  initial begin
    logic [OW-1:0] s[4];
    logic [W-1:0]  d;
    int            pw, pr;

    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.din   = '0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;
    check_reset_values("reset");
    cmp_en = 1'b1;

    // One wide word out as four slices, MSB first.
    s[0] = 72'hA1A1_A1A1_A1A1_A1A1_A1;
    s[1] = 72'hB2B2_B2B2_B2B2_B2B2_B2;
    s[2] = 72'hC3C3_C3C3_C3C3_C3C3_C3;
    s[3] = 72'hD4D4_D4D4_D4D4_D4D4_D4;
    d    = {s[0], s[1], s[2], s[3]};
    step(1'b1, 1'b0, d);
    check("t1_count_after_wr", 96'(bus.rd_count), 96'(4));
    check("t1_empty_after_wr", 96'(bus.empty),    96'(0));
    for (int i = 0; i < 4; i++) begin
`ifdef SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN
      check("t1_fwft_head", 96'(bus.dout), 96'(s[i]));
`endif
      step(1'b0, 1'b1, '0);
`ifndef SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN
      check("t1_dout", 96'(bus.dout), 96'(s[i]));
`endif
      check("t1_count", 96'(bus.rd_count), 96'(3 - i));
    end
    check("t1_empty_end", 96'(bus.empty), 96'(1));

    // Read from empty: dropped, one underflow pulse, dout held.
    step(1'b0, 1'b1, '0);
    check("t4_underflow", 96'(bus.underflow), 96'(1));
    check("t4_count",     96'(bus.rd_count),  96'(0));
`ifndef SYNC_FIFO_WIDE_TO_NARROW_FWFT_EN
    check("t4_dout_held", 96'(bus.dout), 96'(s[3]));
`endif
    step(1'b0, 1'b0, '0);
    check("t4_unf_clear", 96'(bus.underflow), 96'(0));

    // Fill to full, then one rejected write, then drain.
    for (int i = 1; i <= DEPTH; i++) begin
      step(1'b1, 1'b0, rnd_wide());
      if (i == 13) check("t2_af_13",   96'(bus.almost_full), 96'(0));
      if (i == 14) check("t2_af_14",   96'(bus.almost_full), 96'(1));
      if (i == 15) check("t2_full_15", 96'(bus.full),        96'(0));
      if (i == 16) check("t2_full_16", 96'(bus.full),        96'(1));
    end
    check("t2_count_full", 96'(bus.rd_count), 96'(64));
    step(1'b1, 1'b0, rnd_wide());
    check("t2_overflow",   96'(bus.overflow), 96'(1));
    check("t2_count_same", 96'(bus.rd_count), 96'(64));
    step(1'b0, 1'b0, '0);
    check("t2_ovf_clear", 96'(bus.overflow), 96'(0));
    drain(70);
    check("t2_drained", 96'(bus.empty), 96'(1));

    // Full with si=3: freeing read accepted, same-edge write still rejected.
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, rnd_wide());
    repeat (3) step(1'b0, 1'b1, '0);
    check("t3_count_pre", 96'(bus.rd_count), 96'(61));
    check("t3_full_pre",  96'(bus.full),     96'(1));
    step(1'b1, 1'b1, rnd_wide());
    check("t3_overflow", 96'(bus.overflow),    96'(1));
    check("t3_count",    96'(bus.rd_count),    96'(60));
    check("t3_full",     96'(bus.full),        96'(0));
    check("t3_af",       96'(bus.almost_full), 96'(1));
    step(1'b0, 1'b0, '0);
    check("t3_ovf_clear", 96'(bus.overflow), 96'(0));
    drain(80);

    // Random traffic with shifting rates, asynchronous reset mid-stream.
    pw = 50;
    pr = 50;
    for (int c = 0; c < 10000; c++) begin
      if (c % 400 == 0) begin
        pw = $urandom_range(15, 85);
        pr = $urandom_range(15, 85);
      end
      if (c == 5000) begin
        rst = 1'b1;
        #1;
        check_reset_values("midrst");
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(posedge clk);
        #2;
      end
      step($urandom_range(0, 99) < pw, $urandom_range(0, 99) < pr, rnd_wide());
    end
    drain(100);
    step(1'b0, 1'b0, '0);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
